// File: rtl/packet_switch_tx_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : packet_switch_tx_dbg_pkg
//  Description : Shared types, counter index map and sizing helper for the
//                packet-switch TX debug counter update scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package packet_switch_tx_dbg_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        HOLD  = 2'd2
    } dbg_state_e;

    // Counter index map; order matches the CSR port order
    localparam int DMA2IWADJ_BASE  = 0;
    localparam int IWADJ2IARB_BASE = 3;
    localparam int USER_IDX        = 6;
    localparam int IARB2HSSI_IDX   = 7;

    // Smallest pending width whose all-ones value covers one full
    // round-robin rotation of NUM_CNTR sources.
    function automatic int min_pend_width(input int num_cntr);
        for (int k = 1; k < 31; k++) begin
            if (((1 << k) - 1) >= num_cntr) begin
                return k;
            end
        end
        return 31;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_switch_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : packet_switch_rr_arb
//  Description : N-way round-robin arbiter. Search begins one past the last
//                granted index and wraps; the pointer advances only when a
//                grant is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_switch_rr_arb #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    int               w_best;
    int               w_dist;

    // Pick the requester closest (in wrap order) to last_grant+1
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_best  = N;
        w_dist  = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + N - 1 - int'(r_last)) % N;
            if (req_i[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_idx   = IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end

    assign valid_o   = w_found & en_i;
    assign gnt_idx_o = w_idx;
    assign gnt_o     = valid_o ? (N'(1) << w_idx) : '0;

    // Pointer moves only on a real grant; index 0 wins first after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IDX_W'(N - 1);
        end else if (valid_o) begin
            r_last <= w_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/packet_switch_tx_dbg_cntr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : packet_switch_tx_dbg_cntr_sched
//  Description : Collects per-source TX datapath events into small pending
//                accumulators and folds one source per cycle into its CSR
//                counter through a single shared adder. Runs the clear-all
//                and freeze sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_switch_tx_dbg_cntr_sched
    import packet_switch_tx_dbg_pkg::*;
#(
    parameter int NUM_CNTR   = 8,
    parameter int CNTR_WIDTH = 32,
    parameter int PEND_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CNTR-1:0]              evt_i,
    input  logic [NUM_CNTR*CNTR_WIDTH-1:0]   cnt_prev_i,
    output logic [NUM_CNTR*CNTR_WIDTH-1:0]   cnt_next_o,
    input  logic                             clear_req_i,
    output logic                             clear_busy_o,
    input  logic                             freeze_i,
    output logic [NUM_CNTR-1:0]              pend_ovf_o
);

    localparam int IDX_W = (NUM_CNTR > 1) ? $clog2(NUM_CNTR) : 1;

    // A pending accumulator must absorb a full rotation of events
    generate
        if (PEND_WIDTH < min_pend_width(NUM_CNTR)) begin : g_pend_width_check
            $error("PEND_WIDTH too narrow for NUM_CNTR sources");
        end
    endgenerate

    dbg_state_e              r_state;
    dbg_state_e              w_state_nxt;
    logic                    w_clear;
    logic                    w_arb_en;

    logic [PEND_WIDTH-1:0]   r_pend [NUM_CNTR];
    logic [NUM_CNTR-1:0]     r_pend_ovf;

    logic [NUM_CNTR-1:0]     w_req;
    logic [NUM_CNTR-1:0]     w_gnt;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_gnt_vld;

    logic [CNTR_WIDTH-1:0]   w_prev [NUM_CNTR];
    logic [CNTR_WIDTH-1:0]   w_add_base;
    logic [PEND_WIDTH-1:0]   w_add_pend;
    logic [CNTR_WIDTH-1:0]   w_sum;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and sequencing controls; freeze gates grants same-cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_clear      = 1'b0;
        w_arb_en     = 1'b0;
        clear_busy_o = 1'b0;
        case (r_state)
            IDLE: begin
                w_arb_en = ~freeze_i;
                if (clear_req_i) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_clear      = 1'b1;
                clear_busy_o = 1'b1;
                w_state_nxt  = HOLD;
            end
            HOLD: begin
                clear_busy_o = 1'b1;
                if (!clear_req_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    generate
        for (genvar i = 0; i < NUM_CNTR; i++) begin : g_src
            assign w_req[i]  = |r_pend[i];
            assign w_prev[i] = cnt_prev_i[i*CNTR_WIDTH +: CNTR_WIDTH];
            // Only the granted slot sees the adder result; clear overrides all
            assign cnt_next_o[i*CNTR_WIDTH +: CNTR_WIDTH] =
                w_clear  ? '0    :
                w_gnt[i] ? w_sum : w_prev[i];
        end
    endgenerate

    packet_switch_rr_arb #(
        .N     (NUM_CNTR),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (w_req),
        .en_i      (w_arb_en),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx),
        .valid_o   (w_gnt_vld)
    );

    // Single shared adder: selected counter plus its pending count, wrapping
    assign w_add_base = w_prev[w_gnt_idx];
    assign w_add_pend = r_pend[w_gnt_idx];
    assign w_sum      = w_add_base + CNTR_WIDTH'(w_add_pend);

    // Pending accumulators: granted slot restarts from this cycle's event,
    // others saturate and flag any event lost at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                r_pend[i] <= '0;
            end
            r_pend_ovf <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                r_pend[i] <= '0;
            end
            r_pend_ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                if (w_gnt_vld && w_gnt[i]) begin
                    r_pend[i] <= PEND_WIDTH'(evt_i[i]);
                end else if (evt_i[i]) begin
                    if (&r_pend[i]) begin
                        r_pend_ovf[i] <= 1'b1;
                    end else begin
                        r_pend[i] <= r_pend[i] + PEND_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign pend_ovf_o = r_pend_ovf;

endmodule
`default_nettype wire

// File: doc/packet_switch_tx_dbg_cntr_sched.md
# packet_switch_tx_dbg_cntr_sched

Update scheduler for the packet-switch TX debug statistics counters. It collects per-source packet events from the TX datapath taps and holds them in small pending accumulators. Each cycle, a round-robin arbiter grants one shared adder slot that folds one source's pending count into its CSR counter over the cnt_prev/cnt_next register pair. It also runs the clear-all and freeze sequences, and sits between the datapath event taps and the TX debug counter CSR interface.

## Interface
Parameters:
- NUM_CNTR, 8, number of counters (3 dma2iwadj, 4 iwadj2iarb incl. user, 1 iarb2hssi); index order matches CSR port order
- CNTR_WIDTH, 32, CSR counter width
- PEND_WIDTH, 4, pending accumulator width; must satisfy 2^PEND_WIDTH-1 >= NUM_CNTR (elaboration-time assertion)

Ports:
- clk  in  1  sole clock
- rst_n  in  1  reset; asynchronous assert, active-low
- evt_i  in  NUM_CNTR  per-source event pulse, at most one event per source per cycle
- cnt_prev_i  in  NUM_CNTR x CNTR_WIDTH  current CSR counter values
- cnt_next_o  out  NUM_CNTR x CNTR_WIDTH  next CSR counter values (CSR write-enable is tied high)
- clear_req_i  in  1  level request to zero all counters
- clear_busy_o  out  1  clear sequence in progress
- freeze_i  in  1  suspend counter updates; events keep accumulating
- pend_ovf_o  out  NUM_CNTR  sticky flag: event lost to pending saturation

## Operation
- Pending accumulators pend[i] are PEND_WIDTH bits, reset to 0.
- Grant: a combinational round-robin pick among i with pend[i]!=0.
  - Search starts at last_grant+1 and wraps modulo NUM_CNTR.
  - last_grant resets to NUM_CNTR-1, so index 0 wins first.
  - No grant while freeze_i=1 or while state is not IDLE.
- cnt_next_o[g] = cnt_prev_i[g] + pend[g] for the granted g, modulo 2^CNTR_WIDTH (wraps, no saturation).
- For every other i, cnt_next_o[i] = cnt_prev_i[i].
- Pending update per cycle:
  - Granted source: pend <= evt_i[i]. The same-cycle event is kept.
  - Other sources: pend <= pend + evt_i[i], saturating at all-ones.
  - An increment attempted at all-ones sets pend_ovf_o[i]. The flag stays set until the next clear.
- last_grant is updated only on a cycle where a grant is made.
- State machine (registered):
  - IDLE: normal operation. clear_req_i=1 -> CLEAR.
  - CLEAR (one cycle): cnt_next_o = 0 for all counters. pend and pend_ovf are zeroed; evt_i in this cycle is discarded. Next state is HOLD.
  - HOLD: no grants; events accumulate into the zeroed pend. clear_req_i=0 -> IDLE.
- clear_busy_o = 1 in CLEAR and HOLD.
- Clear has priority over freeze. While frozen, the CLEAR cycle still zeroes the counters.
- Starvation bound: any nonzero pend is serviced within NUM_CNTR unfrozen IDLE cycles. This means no overflow under 1 event/cycle unless frozen.

## Timing
- Reset values:
  - state = IDLE, pend = 0, pend_ovf_o = 0, clear_busy_o = 0, last_grant = NUM_CNTR-1.
  - cnt_next_o = cnt_prev_i (no grant, since pend = 0).
- Reset asserted mid-operation: pending counts are dropped. Counters already in the CSR are unaffected.
- Event-to-CSR latency:
  - Event at cycle t enters pend at t+1.
  - With an immediate grant at t+1, the CSR register holds the new value at t+2.
  - Worst case unfrozen: t+1+NUM_CNTR.
- cnt_next_o is combinational from registered state and cnt_prev_i. There is no combinational path from evt_i, clear_req_i or freeze_i to cnt_next_o.
  - Exception: freeze_i gates the grant combinationally. Freeze therefore takes effect the same cycle.
- Counter reads zero at CSR two cycles after clear_req_i rises: rise at t, CLEAR at t+1, CSR = 0 at t+2.

## Structure
- Package packet_switch_tx_dbg_pkg holds:
  - the state enum (IDLE, CLEAR, HOLD)
  - counter index localparams (DMA2IWADJ_BASE=0, IWADJ2IARB_BASE=3, USER_IDX=6, IARB2HSSI_IDX=7)
  - the PEND_WIDTH sizing function
- Sub-module packet_switch_rr_arb: parameterized N-way round-robin arbiter.
  - Inputs: req vector, enable.
  - Outputs: one-hot grant, grant index, valid.
  - Owns the last_grant pointer register.

## Test plan
- Reset, then evt_i[0] pulses at cycles 0..4 with cnt_prev=0 -> cnt_next_o[0] increments by 1 each cycle from cycle 1; CSR reads 5 at cycle 6; pend_ovf_o=0.
- All 8 evt_i high for 16 cycles -> grants rotate 0,1,...,7,0; each counter reaches 16 within 8 cycles after the events stop; no pend_ovf.
- freeze_i=1 while evt_i[3] is high for 20 cycles -> cnt_next_o[3]=cnt_prev_i[3] throughout; pend[3] saturates at 15; pend_ovf_o[3]=1; after unfreeze counter[3] += 15 in one update.
- Counter[7] at 0xFFFF_FFFE, pend=3 -> cnt_next_o[7]=0x0000_0001 (wrap).
- clear_req_i pulses for 3 cycles while events are active -> clear_busy_o high for 3 cycles, all cnt_next_o=0 for exactly one cycle, pend_ovf cleared, HOLD-cycle events counted afterward.
- rst_n asserted asynchronously with pend[2]=5 -> pend cleared immediately; no update to counter[2] after release.
